gold_nic: RTL and testbench
===========================

GOLD_NIC -- requirements
Module: gold_nic

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the packet width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the entries per channel FIFO (power of two).
REQ-003 Port clk, input, 1: the clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous, active-high.
REQ-005 Port addr, input, 2: register select: 0 = RX buffer, 1 = RX status, 2 = TX buffer, 3 = TX status.
REQ-006 Port d_in, input, DATA_W: processor write data.
REQ-007 Port d_out, output, DATA_W: registered processor read data.
REQ-008 Port nic_en, input, 1: processor access enable.
REQ-009 Port nic_wr_en, input, 1: 1 = write, 0 = read; qualified by nic_en.
REQ-010 Port net_si, input, 1: router-to-NIC send strobe, from the router PE output port.
REQ-011 Port net_ri, output, 1: NIC ready to accept from the router.
REQ-012 Port net_di, input, DATA_W: router-to-NIC packet.
REQ-013 Port net_so, output, 1: NIC-to-router send strobe, to the router PE input port.
REQ-014 Port net_ro, input, 1: router ready to accept from the NIC.
REQ-015 Port net_do, output, DATA_W: NIC-to-router packet.
REQ-016 Port net_polarity, input, 1: router cycle polarity (0 = even, 1 = odd).

Function
REQ-017 Packet fields SHALL be: [63] VC (0 = even, 1 = odd), [62] direction (0 = cw, 1 = ccw), [55:48] hop bitmap, [31:0] payload; the NIC SHALL never modify them.
REQ-018 RX path: net_ri SHALL equal !rx_full, combinationally; on an edge with net_si && net_ri, net_di SHALL push into the RX FIFO.
REQ-019 An edge with net_si && !net_ri SHALL be ignored and counted as neither a push nor an error.
REQ-020 Read at addr 0 (nic_en && !nic_wr_en) SHALL load d_out with the RX head next edge and pop it if rx_count > 0; an empty read SHALL load 0 and leave state unchanged.
REQ-021 RX push and pop on the same edge SHALL both take effect; count unchanged, order preserved.
REQ-022 A status read (addr 1/3) SHALL load d_out with {16'b0, pkt_cnt[15:0], 28'b0, full, empty, count[1:0]} for RX or TX respectively.
REQ-023 TX path: a write at addr 2 SHALL push d_in if tx_full is 0 pre-edge; otherwise it SHALL be dropped silently.
REQ-024 Writes to addr 0, 1 and 3 SHALL be ignored; a read at addr 2 SHALL return 0.
REQ-025 net_so SHALL equal !tx_empty && net_ro && (tx_head[63] == net_polarity), combinationally, and net_do SHALL always present tx_head.
REQ-026 The TX FIFO SHALL pop on every edge where net_so = 1, giving one packet per matching cycle.
REQ-027 A TX push and pop on the same edge SHALL both succeed; fullness SHALL be judged on the pre-edge state.
REQ-028 A head packet whose VC mismatches polarity SHALL wait, and SHALL not be bypassed by later entries.
REQ-029 rx_pkt_cnt and tx_pkt_cnt, 16 bits each, SHALL increment per accepted network transfer and wrap 0xFFFF -> 0x0000.
REQ-030 d_out SHALL hold its value on edges without a read.

Reset
REQ-031 Reset SHALL set both FIFOs empty, both counters to 0, and d_out to 0; net_ri SHALL be 1 and net_so SHALL be 0 during reset and after it.
REQ-032 Reset mid-transfer SHALL discard all buffered packets; no transfer SHALL complete on the edge where reset is active.

Structure
REQ-033 Shared package gold_noc_pkg SHALL hold DATA_W, the field bit positions (VC, DIR, HOP_HI/LO, PAYLOAD) and the register address constants.
REQ-034 One sub-module gold_nic_fifo (synchronous FIFO, DEPTH entries, pointer-wrap full/empty, simultaneous push/pop) SHALL be instantiated twice, once for RX and once for TX.

Verification
REQ-035 Reset, then write 0x0000_0000_0000_00AA to addr 2 with net_polarity = 0 and net_ro = 1 -> net_so = 1 on the next cycle with net_do = 0xAA, then the TX status count = 0 and tx_pkt_cnt = 1.
REQ-036 Push a TX packet with bit 63 = 1 while polarity toggles starting at 0 -> net_so stays 0 on even cycles and is asserted exactly once on the first odd cycle.
REQ-037 Two router pushes 0x11 then 0x22 -> net_ri = 0 after the second; RX status reads full = 1 and count = 2; reads at addr 0 return 0x11 then 0x22; net_ri returns to 1.
REQ-038 Hold net_ro = 0 and write 3 packets to addr 2 -> the third is dropped; after releasing net_ro with matching polarity, exactly 2 packets are sent in order.
REQ-039 With the RX FIFO at count 1, drive a router push and a processor read on the same edge -> d_out gets the old head and count stays 1.
REQ-040 Assert reset while the TX FIFO holds 2 packets -> net_so = 0 immediately, TX status = empty, and tx_pkt_cnt = 0.

Source files
------------

// File: rtl/gold_noc_pkg.sv
// gold_noc_pkg: shared NoC packet field positions, NIC register map and status-word helper
package gold_noc_pkg;
  localparam int DATA_W     = 64;
  localparam int VC_BIT     = 63;
  localparam int DIR_BIT    = 62;
  localparam int HOP_HI     = 55;
  localparam int HOP_LO     = 48;
  localparam int PAYLOAD_HI = 31;
  localparam int PAYLOAD_LO = 0;

  typedef enum logic [1:0] {
    REG_RX_BUF  = 2'd0,
    REG_RX_STAT = 2'd1,
    REG_TX_BUF  = 2'd2,
    REG_TX_STAT = 2'd3
  } reg_addr_e;

  function automatic logic [63:0] status_word(input logic [15:0] pkt_cnt, input logic full,
                                              input logic empty, input logic [1:0] count);
    return {16'b0, pkt_cnt, 28'b0, full, empty, count};
  endfunction
endpackage

// File: rtl/gold_nic_fifo.sv
// gold_nic_fifo: synchronous FIFO with wrap-bit pointers and simultaneous push/pop
module gold_nic_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;
  logic         w_push, w_pop;

  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_count = r_wp - r_rp;
  assign o_head  = r_mem[r_rp[AW-1:0]];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // pointers advance on accepted push/pop; fullness is judged on the pre-edge state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end

  // storage needs no reset; pointers alone define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/gold_nic.sv
// gold_nic: processor-to-router network interface with RX/TX packet FIFOs and VC-polarity gated send
module gold_nic #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nic_en,
  input  logic              nic_wr_en,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity
);
  import gold_noc_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] w_rx_head, w_tx_head, w_rd_data, w_rx_stat, w_tx_stat;
  logic              w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic [CW-1:0]     w_rx_count, w_tx_count;
  logic              w_rd, w_rx_push, w_rx_pop, w_tx_push;
  logic [15:0]       r_rx_pkt_cnt, r_tx_pkt_cnt;
  logic [DATA_W-1:0] r_d_out;

  assign w_rd      = nic_en && !nic_wr_en;
  assign w_rx_pop  = w_rd && addr == REG_RX_BUF;
  assign w_tx_push = nic_en && nic_wr_en && addr == REG_TX_BUF;
  assign net_ri    = !w_rx_full;
  assign w_rx_push = net_si && net_ri;
  assign net_so    = !w_tx_empty && net_ro && (w_tx_head[VC_BIT] == net_polarity);
  assign net_do    = w_tx_head;
  assign d_out     = r_d_out;
  assign w_rx_stat = DATA_W'(status_word(r_rx_pkt_cnt, w_rx_full, w_rx_empty, 2'(w_rx_count)));
  assign w_tx_stat = DATA_W'(status_word(r_tx_pkt_cnt, w_tx_full, w_tx_empty, 2'(w_tx_count)));

  gold_nic_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .reset(reset), .i_push(w_rx_push), .i_data(net_di), .i_pop(w_rx_pop),
    .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  gold_nic_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .reset(reset), .i_push(w_tx_push), .i_data(d_in), .i_pop(net_so),
    .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  // register-map read mux; empty RX buffer and TX buffer reads return zero
  always_comb begin
    w_rd_data = addr == REG_RX_BUF  ? (w_rx_empty ? '0 : w_rx_head) :
                addr == REG_RX_STAT ? w_rx_stat :
                addr == REG_TX_STAT ? w_tx_stat : '0;
  end

  // read data register and per-direction accepted-transfer counters (wrap naturally)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_out      <= '0;
      r_rx_pkt_cnt <= '0;
      r_tx_pkt_cnt <= '0;
    end else begin
      if (w_rd) r_d_out <= w_rd_data;
      if (w_rx_push) r_rx_pkt_cnt <= r_rx_pkt_cnt + 16'd1;
      if (net_so) r_tx_pkt_cnt <= r_tx_pkt_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_gold_nic.sv
// tb_gold_nic: scoreboard bench for gold_nic covering directed scenarios and a random mix
module tb_gold_nic;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out, net_di, net_do;
  logic        nic_en, nic_wr_en, net_si, net_ri, net_so, net_ro, net_polarity;

  int checks = 0;
  int errors = 0;
  logic [63:0] rxq[$];
  logic [63:0] txq[$];
  logic [15:0] m_rx_cnt, m_tx_cnt;
  logic [63:0] m_dout;

  always #5 clk = ~clk;

  gold_nic dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nic_en(nic_en), .nic_wr_en(nic_wr_en), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] stat(input logic [15:0] c, input int n);
    return {16'b0, c, 28'b0, n == 2, n == 0, 2'(n)};
  endfunction

  task automatic flush_model();
    rxq.delete();
    txq.delete();
    m_rx_cnt = '0;
    m_tx_cnt = '0;
    m_dout   = '0;
  endtask

  task automatic step(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] din,
                      input logic si, input logic [63:0] di, input logic ro, input logic pol);
    bit exp_ri, exp_so, rx_push, tx_push;
    @(negedge clk);
    nic_en = en; nic_wr_en = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    #1;
    exp_ri = rxq.size() < 2;
    exp_so = txq.size() > 0 && ro && txq[0][63] == pol;
    check("net_ri", 64'(net_ri), 64'(exp_ri));
    check("net_so", 64'(net_so), 64'(exp_so));
    if (exp_so) check("net_do", net_do, txq[0]);
    if (en && !wr)
      m_dout = a == 2'd0 ? (rxq.size() > 0 ? rxq[0] : 64'd0) :
               a == 2'd1 ? stat(m_rx_cnt, rxq.size()) :
               a == 2'd3 ? stat(m_tx_cnt, txq.size()) : 64'd0;
    rx_push = si && exp_ri;
    tx_push = en && wr && a == 2'd2 && txq.size() < 2;
    if (en && !wr && a == 2'd0 && rxq.size() > 0) void'(rxq.pop_front());
    if (rx_push) begin rxq.push_back(di); m_rx_cnt++; end
    if (exp_so) begin void'(txq.pop_front()); m_tx_cnt++; end
    if (tx_push) txq.push_back(din);
    @(posedge clk);
    #1;
    check("d_out", d_out, m_dout);
  endtask

  task automatic idle(input logic ro, input logic pol);
    step(0, 0, 2'd0, 64'd0, 0, 64'd0, ro, pol);
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d, input logic ro, input logic pol);
    step(1, 1, a, d, 0, 64'd0, ro, pol);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1, 0, a, 64'd0, 0, 64'd0, 0, 0);
  endtask

  task automatic push_rx(input logic [63:0] d);
    step(0, 0, 2'd0, 64'd0, 1, d, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    flush_model();
    check("rst_ri", 64'(net_ri), 64'd1);
    check("rst_so", 64'(net_so), 64'd0);
    check("rst_dout", d_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; d_in = '0; net_di = '0;
    nic_en = 0; nic_wr_en = 0; net_si = 0; net_ro = 0; net_polarity = 0;
    flush_model();
    do_reset();
    rd(2'd1);
    rd(2'd3);
    // single TX send with matching even polarity
    wr(2'd2, 64'h0000_0000_0000_00AA, 1, 0);
    idle(1, 0);
    rd(2'd3);
    // odd-VC packet waits through even cycles, goes once on the first odd one
    wr(2'd2, 64'h8000_0000_0000_0001, 1, 0);
    idle(1, 0);
    idle(1, 1);
    idle(1, 0);
    idle(1, 1);
    // RX fill, status, drain
    push_rx(64'h11);
    push_rx(64'h22);
    push_rx(64'h33);
    rd(2'd1);
    rd(2'd0);
    rd(2'd0);
    rd(2'd0);
    rd(2'd1);
    // TX overflow drop while router stalls, then in-order release
    wr(2'd2, 64'h1, 0, 0);
    wr(2'd2, 64'h2, 0, 0);
    wr(2'd2, 64'h3, 0, 0);
    rd(2'd3);
    idle(1, 0);
    idle(1, 0);
    idle(1, 0);
    // simultaneous RX push and pop at count 1
    push_rx(64'h44);
    step(1, 0, 2'd0, 64'd0, 1, 64'h55, 0, 0);
    rd(2'd1);
    rd(2'd0);
    // ignored register writes and zero TX-buffer read
    wr(2'd0, 64'hDEAD, 0, 0);
    wr(2'd1, 64'hBEEF, 0, 0);
    wr(2'd3, 64'hCAFE, 0, 0);
    rd(2'd2);
    rd(2'd1);
    rd(2'd3);
    // reset while TX holds two sendable packets
    wr(2'd2, 64'h7, 0, 0);
    wr(2'd2, 64'h8, 0, 0);
    @(negedge clk);
    nic_en = 0; net_si = 0; net_ro = 1; net_polarity = 0;
    #1;
    check("pre_rst_so", 64'(net_so), 64'd1);
    reset = 1'b1;
    #1;
    flush_model();
    check("rst_mid_so", 64'(net_so), 64'd0);
    check("rst_mid_ri", 64'(net_ri), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd3);
    rd(2'd1);
    // random mix against the scoreboard
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
           {$urandom, $urandom}, $urandom_range(0, 1), {$urandom, $urandom},
           $urandom_range(0, 1), $urandom_range(0, 1));
    rd(2'd1);
    rd(2'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
